// File: rtl/sd_card_cmd_responder_if.sv
// Command/response bundle between the SD CMD responder (slave) and the card logic / line driver (master).
`timescale 1ns/1ps
interface sd_card_cmd_responder_if;
  logic         sd_clk_en;
  logic         cmd_in;
  logic         cmd_out;
  logic         cmd_oe;
  logic         cmd_valid;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         cmd_crc_err;
  logic         cmd_frame_err;
  logic         rsp_start;
  logic [1:0]   rsp_type;
  logic [5:0]   rsp_index;
  logic [127:0] rsp_data;
  logic         rsp_busy;
  logic         rsp_done;

  modport slave (
    input  sd_clk_en, cmd_in, rsp_start, rsp_type, rsp_index, rsp_data,
    output cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, cmd_crc_err,
           cmd_frame_err, rsp_busy, rsp_done
  );

  modport master (
    output sd_clk_en, cmd_in, rsp_start, rsp_type, rsp_index, rsp_data,
    input  cmd_out, cmd_oe, cmd_valid, cmd_index, cmd_arg, cmd_crc_err,
           cmd_frame_err, rsp_busy, rsp_done
  );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit commands, checks framing/CRC7, sends R1/R2/R3 responses.
// Receive CRC7 check is enabled only when SD_CARD_RSP_CRC_CHECK_EN is defined.
`timescale 1ns/1ps
module sd_card_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic                    ex_clk,
  input  logic                    ex_resetn,
  sd_card_cmd_responder_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CHECK, S_WAIT_RSP, S_NCR_WAIT, S_TX
  } state_t;

  localparam logic [7:0] RX_LEN    = 8'd48;
  localparam logic [7:0] CRC_START = 8'd40;
  localparam logic [7:0] CRC_END   = 8'd47;
  localparam logic [6:0] NCR_TICKS = 7'(NCR);

  state_t       state;
  logic [47:0]  rx_sr;
  logic [135:0] tx_sr;
  logic [7:0]   bit_cnt;
  logic [7:0]   tx_len;
  logic         tx_crc_en;
  logic [6:0]   crc;
  logic [6:0]   ncr_cnt;
  logic         tx_bit;
  logic         tick;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  assign tick = bus.sd_clk_en;

  // In R1 the CRC register is shifted out over the frame's CRC field.
  always_comb begin
    tx_bit = tx_sr[135];
    if (tx_crc_en && bit_cnt >= CRC_START && bit_cnt < CRC_END) tx_bit = crc[6];
  end

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state             <= S_IDLE;
      rx_sr             <= '0;
      tx_sr             <= '0;
      bit_cnt           <= '0;
      tx_len            <= RX_LEN;
      tx_crc_en         <= 1'b0;
      crc               <= '0;
      ncr_cnt           <= '0;
      bus.cmd_out       <= 1'b1;
      bus.cmd_oe        <= 1'b0;
      bus.cmd_valid     <= 1'b0;
      bus.cmd_index     <= '0;
      bus.cmd_arg       <= '0;
      bus.cmd_crc_err   <= 1'b0;
      bus.cmd_frame_err <= 1'b0;
      bus.rsp_busy      <= 1'b0;
      bus.rsp_done      <= 1'b0;
    end else begin
      bus.cmd_valid     <= 1'b0;
      bus.cmd_crc_err   <= 1'b0;
      bus.cmd_frame_err <= 1'b0;
      bus.rsp_done      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tick && !bus.cmd_in) begin
            rx_sr   <= {rx_sr[46:0], 1'b0};
            bit_cnt <= 8'd1;
            crc     <= '0;
            state   <= S_RX;
          end
        end

        S_RX: begin
          if (tick) begin
            rx_sr <= {rx_sr[46:0], bus.cmd_in};
            if (bit_cnt < CRC_START) crc <= crc7_step(crc, bus.cmd_in);
            if (bit_cnt < RX_LEN) bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == RX_LEN - 8'd1) state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (rx_sr[47] || !rx_sr[46] || !rx_sr[0]) begin
            bus.cmd_frame_err <= 1'b1;
            state             <= S_IDLE;
          end
`ifdef SD_CARD_RSP_CRC_CHECK_EN
          else if (crc != rx_sr[7:1]) begin
            bus.cmd_crc_err <= 1'b1;
            state           <= S_IDLE;
          end
`endif
          else begin
            bus.cmd_index <= rx_sr[45:40];
            bus.cmd_arg   <= rx_sr[39:8];
            bus.cmd_valid <= 1'b1;
            state         <= S_WAIT_RSP;
          end
        end

        S_WAIT_RSP: begin
          // A new start bit abandons the pending command, even against a same-cycle rsp_start.
          if (tick && !bus.cmd_in) begin
            rx_sr   <= {rx_sr[46:0], 1'b0};
            bit_cnt <= 8'd1;
            crc     <= '0;
            state   <= S_RX;
          end else if (bus.rsp_start) begin
            case (bus.rsp_type)
              2'd1: begin
                tx_sr     <= {2'b00, 6'h3F, bus.rsp_data[127:1], 1'b1};
                tx_len    <= 8'd136;
                tx_crc_en <= 1'b0;
              end
              2'd2: begin
                tx_sr     <= {2'b00, 6'h3F, bus.rsp_data[31:0], 7'h7F, 1'b1, 88'd0};
                tx_len    <= RX_LEN;
                tx_crc_en <= 1'b0;
              end
              default: begin
                tx_sr     <= {2'b00, bus.rsp_index, bus.rsp_data[31:0], 7'd0, 1'b1, 88'd0};
                tx_len    <= RX_LEN;
                tx_crc_en <= 1'b1;
              end
            endcase
            bus.rsp_busy <= 1'b1;
            ncr_cnt      <= '0;
            state        <= S_NCR_WAIT;
          end
        end

        S_NCR_WAIT: begin
          if (tick) begin
            if (ncr_cnt == NCR_TICKS) begin
              bus.cmd_oe  <= 1'b1;
              bus.cmd_out <= tx_sr[135];
              tx_sr       <= {tx_sr[134:0], 1'b0};
              crc         <= crc7_step(7'd0, tx_sr[135]);
              bit_cnt     <= 8'd1;
              state       <= S_TX;
            end else begin
              ncr_cnt <= ncr_cnt + 7'd1;
            end
          end
        end

        S_TX: begin
          if (tick) begin
            if (bit_cnt == tx_len) begin
              bus.cmd_oe   <= 1'b0;
              bus.cmd_out  <= 1'b1;
              bus.rsp_done <= 1'b1;
              bus.rsp_busy <= 1'b0;
              state        <= S_IDLE;
            end else begin
              bus.cmd_out <= tx_bit;
              tx_sr       <= {tx_sr[134:0], 1'b0};
              if (tx_crc_en && bit_cnt >= CRC_START) crc <= {crc[5:0], 1'b0};
              else if (bit_cnt < CRC_START) crc <= crc7_step(crc, tx_bit);
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Randomised self-checking bench for sd_card_cmd_responder against a frame-level reference model.
`timescale 1ns/1ps
module tb_sd_card_cmd_responder;
  localparam int NCR = 2;
`ifdef SD_CARD_RSP_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic ex_resetn;
  always #5 clk = ~clk;

  sd_card_cmd_responder_if bus();

  sd_card_cmd_responder #(.NCR(NCR)) dut (
    .ex_clk    (clk),
    .ex_resetn (ex_resetn),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0, crc_err_cnt = 0, frame_err_cnt = 0, done_cnt = 0;
  logic [5:0]  last_idx;
  logic [31:0] last_arg;

  always @(negedge clk) begin
    if (bus.cmd_valid) begin
      valid_cnt++;
      last_idx = bus.cmd_index;
      last_arg = bus.cmd_arg;
    end
    if (bus.cmd_crc_err)   crc_err_cnt++;
    if (bus.cmd_frame_err) frame_err_cnt++;
    if (bus.rsp_done)      done_cnt++;
  end

  task automatic chk_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CRC7 as polynomial remainder of m(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, ref_crc7(h), 1'b1};
  endfunction

  function automatic logic [135:0] ref_rsp(input logic [1:0] t, input logic [5:0] idx,
                                           input logic [127:0] d);
    logic [39:0] h;
    case (t)
      2'd1:    return {2'b00, 6'h3F, d[127:1], 1'b1};
      2'd2:    return {88'd0, 2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1};
      default: begin
        h = {2'b00, idx, d[31:0]};
        return {88'd0, h, ref_crc7(h), 1'b1};
      end
    endcase
  endfunction

  task automatic tick();
    bus.sd_clk_en = 1'b1;
    @(negedge clk);
    bus.sd_clk_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_in = f[i];
      tick();
    end
    bus.cmd_in = 1'b1;
  endtask

  task automatic do_rsp(input logic [1:0] t, input logic [5:0] idx, input logic [127:0] d,
                        output logic [135:0] got);
    int n, d0, oe_bad;
    n      = (t == 2'd1) ? 136 : 48;
    d0     = done_cnt;
    oe_bad = 0;
    got    = '0;
    bus.rsp_type  = t;
    bus.rsp_index = idx;
    bus.rsp_data  = d;
    bus.rsp_start = 1'b1;
    @(negedge clk);
    bus.rsp_start = 1'b0;
    chk_eq("busy_rise", bus.rsp_busy, 1);
    for (int i = 0; i < NCR; i++) begin
      tick();
      chk_eq("ncr_gap_oe", bus.cmd_oe, 0);
    end
    for (int i = 0; i < n; i++) begin
      tick();
      got = {got[134:0], bus.cmd_out};
      if (bus.cmd_oe !== 1'b1) oe_bad++;
    end
    chk_eq("tx_oe_held", oe_bad, 0);
    tick();
    chk_eq("post_oe", bus.cmd_oe, 0);
    chk_eq("post_out", bus.cmd_out, 1);
    chk_eq("rsp_done", done_cnt - d0, 1);
    chk_eq("busy_fall", bus.rsp_busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] got;
    logic [127:0] rd;
    logic [47:0]  f;
    logic [5:0]   ci, ri;
    logic [31:0]  ca;
    logic [1:0]   t;
    bit           corrupt, exp_valid;
    int           v0, c0, f0, d0, b;

    bus.sd_clk_en = 1'b0;
    bus.cmd_in    = 1'b1;
    bus.rsp_start = 1'b0;
    bus.rsp_type  = 2'd0;
    bus.rsp_index = 6'd0;
    bus.rsp_data  = '0;
    ex_resetn     = 1'b0;
    repeat (3) @(negedge clk);

    chk_eq("rst_cmd_out", bus.cmd_out, 1);
    chk_eq("rst_cmd_oe", bus.cmd_oe, 0);
    chk_eq("rst_index", bus.cmd_index, 0);
    chk_eq("rst_arg", bus.cmd_arg, 0);
    chk_eq("rst_busy", bus.rsp_busy, 0);
    chk_eq("rst_pulses", {bus.cmd_valid, bus.cmd_crc_err, bus.cmd_frame_err, bus.rsp_done}, 0);
    ex_resetn = 1'b1;
    @(negedge clk);

    // rsp_start outside WAIT_RSP must be ignored
    bus.rsp_start = 1'b1;
    @(negedge clk);
    bus.rsp_start = 1'b0;
    repeat (NCR + 3) tick();
    chk_eq("idle_rsp_busy", bus.rsp_busy, 0);
    chk_eq("idle_rsp_oe", bus.cmd_oe, 0);

    v0 = valid_cnt; c0 = crc_err_cnt; f0 = frame_err_cnt;
    send_cmd(48'h40_00000000_95);
    chk_eq("cmd0_valid", valid_cnt - v0, 1);
    chk_eq("cmd0_index", last_idx, 0);
    chk_eq("cmd0_arg", last_arg, 0);
    chk_eq("cmd0_errs", (crc_err_cnt - c0) + (frame_err_cnt - f0), 0);

    v0 = valid_cnt;
    send_cmd(48'h48_000001AA_87);
    chk_eq("cmd8_valid", valid_cnt - v0, 1);
    chk_eq("cmd8_index", bus.cmd_index, 8);
    chk_eq("cmd8_arg", bus.cmd_arg, 32'h1AA);
    do_rsp(2'd0, 6'd8, 128'h1AA, got);
    chk_eq("r1_echo", got, {88'd0, 48'h08_000001AA_13});

    v0 = valid_cnt; c0 = crc_err_cnt;
    send_cmd(48'h51_00000000_57);
    chk_eq("cmd17_valid", valid_cnt - v0, !CRC_CHK);
    chk_eq("cmd17_crc_err", crc_err_cnt - c0, CRC_CHK);

    v0 = valid_cnt;
    send_cmd(mk_cmd(6'd41, $urandom));
    chk_eq("acmd41_valid", valid_cnt - v0, 1);
    do_rsp(2'd2, 6'd0, 128'h00FF8000, got);
    chk_eq("r3_frame", got, {88'd0, 48'h3F_00FF8000_FF});

    send_cmd(mk_cmd(6'd2, 32'd0));
    rd = {$urandom, $urandom, $urandom, $urandom};
    rd[7:0] = 8'hA5;
    do_rsp(2'd1, 6'd0, rd, got);
    chk_eq("r2_frame", got, ref_rsp(2'd1, 6'd0, rd));

    v0 = valid_cnt; c0 = crc_err_cnt; f0 = frame_err_cnt;
    f = mk_cmd(6'd13, $urandom);
    f[0] = 1'b0;
    send_cmd(f);
    f = mk_cmd(6'd7, $urandom);
    f[46] = 1'b0;
    send_cmd(f);
    chk_eq("frame_err_cnt", frame_err_cnt - f0, 2);
    chk_eq("frame_err_valid", valid_cnt - v0, 0);
    chk_eq("frame_err_crc", crc_err_cnt - c0, 0);

    for (int k = 0; k < 10; k++) begin
      ci = 6'($urandom_range(0, 63));
      ca = $urandom;
      corrupt = ($urandom_range(0, 3) == 0);
      f = mk_cmd(ci, ca);
      if (corrupt) begin
        b = $urandom_range(1, 7);
        f[b] = ~f[b];
      end
      v0 = valid_cnt; c0 = crc_err_cnt;
      send_cmd(f);
      exp_valid = !corrupt || !CRC_CHK;
      chk_eq("rnd_valid", valid_cnt - v0, exp_valid);
      chk_eq("rnd_crc_err", crc_err_cnt - c0, corrupt && CRC_CHK);
      if (exp_valid) begin
        chk_eq("rnd_index", last_idx, ci);
        chk_eq("rnd_arg", last_arg, ca);
        if ($urandom_range(0, 3) != 0) begin
          t  = 2'($urandom_range(0, 3));
          ri = 6'($urandom_range(0, 63));
          rd = {$urandom, $urandom, $urandom, $urandom};
          do_rsp(t, ri, rd, got);
          chk_eq("rnd_rsp", got, ref_rsp(t, ri, rd));
        end
      end
    end

    // Reset in the middle of an R1 transmission
    v0 = valid_cnt;
    send_cmd(48'h48_000001AA_87);
    chk_eq("mid_cmd8_valid", valid_cnt - v0, 1);
    d0 = done_cnt;
    bus.rsp_type  = 2'd0;
    bus.rsp_index = 6'd8;
    bus.rsp_data  = 128'h1AA;
    bus.rsp_start = 1'b1;
    @(negedge clk);
    bus.rsp_start = 1'b0;
    repeat (NCR + 20) tick();
    chk_eq("mid_tx_oe", bus.cmd_oe, 1);
    ex_resetn = 1'b0;
    #1;
    chk_eq("rst_now_oe", bus.cmd_oe, 0);
    chk_eq("rst_now_out", bus.cmd_out, 1);
    chk_eq("rst_now_busy", bus.rsp_busy, 0);
    chk_eq("rst_now_index", bus.cmd_index, 0);
    @(negedge clk);
    ex_resetn = 1'b1;
    repeat (3) tick();
    chk_eq("rst_no_done", done_cnt - d0, 0);
    chk_eq("rst_idle_oe", bus.cmd_oe, 0);
    v0 = valid_cnt;
    send_cmd(48'h40_00000000_95);
    chk_eq("post_rst_valid", valid_cnt - v0, 1);
    chk_eq("post_rst_index", last_idx, 0);
    chk_eq("post_rst_arg", last_arg, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
